spi_frame_rx: RTL and testbench

Synchronous SPI (mode 0) frame receiver that sits directly upstream of the PWM/clock-divider write decoder. It oversamples the external `sck`, `cs_n` and `mosi` pins in the system clock domain and shifts in exactly `FRAME_BITS` bits MSB-first per chip-select window. A complete frame is presented on a ready/valid output holding register. Short or long frames are rejected with an error pulse, and frames arriving while the holding register is still full are dropped with an overrun pulse.

---
 rtl/spi_frame_rx_if.sv | 21 ++
 rtl/spi_frame_rx.sv | 124 ++++++++++++
 tb/tb_spi_frame_rx.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_rx_if.sv
// Output-side bundle of the SPI frame receiver: holding register, handshake and status pulses.
interface spi_frame_rx_if #(
  parameter int FRAME_BITS = 16
);
  logic [FRAME_BITS-1:0] frame_data;
  logic                  frame_valid;
  logic                  frame_ready;
  logic                  frame_err;
  logic                  overrun;
  logic                  busy;

  modport master (
    output frame_data, frame_valid, frame_err, overrun, busy,
    input  frame_ready
  );

  modport slave (
    input  frame_data, frame_valid, frame_err, overrun, busy,
    output frame_ready
  );
endinterface

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: oversamples sck/cs_n/mosi in the clk domain and presents
// fixed-length MSB-first frames on a ready/valid holding register.
//
//   state | meaning
//   IDLE  | waiting for a cs_n fall; sck edges ignored
//   RECV  | chip select active; shifting bits on each sck rise
module spi_frame_rx #(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          sck_in_i,
  input  logic          cs_n_in_i,
  input  logic          mosi_in_i,
  spi_frame_rx_if.master frm_if
);

  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

  typedef enum logic {IDLE, RECV} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q, vld_q;
  logic                   sck_prev_q, cs_prev_q, armed_q;
  logic                   sck_rise_q, cs_rise_q, cs_fall_q, mosi_smp_q;
  logic                   sck_rise_d, cs_rise_d, cs_fall_d;
  logic                   sck_s, cs_s, mosi_s, sync_ok;

  state_t                 state_q;
  logic [FRAME_BITS-1:0]  shift_q, data_q;
  logic [CW-1:0]          cnt_q;
  logic                   valid_q, err_q, ovr_q, busy_q;

  assign sck_s   = sck_sync_q[SYNC_STAGES-1];
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign sync_ok = vld_q[SYNC_STAGES-1];

  // A cs_n fall only counts once a genuine high has been seen since reset, so a
  // frame already in progress at reset release is never picked up half-way.
  assign sck_rise_d = sck_s & ~sck_prev_q;
  assign cs_rise_d  = cs_s & ~cs_prev_q;
  assign cs_fall_d  = armed_q & ~cs_s & cs_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      vld_q       <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
      sck_rise_q  <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
      mosi_smp_q  <= 1'b0;
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_in_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_in_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in_i};
      vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      armed_q     <= armed_q | (sync_ok & cs_s);
      sck_rise_q  <= sck_rise_d;
      cs_rise_q   <= cs_rise_d;
      cs_fall_q   <= cs_fall_d;
      mosi_smp_q  <= mosi_s;

      err_q <= 1'b0;
      ovr_q <= 1'b0;
      if (valid_q && frm_if.frame_ready) valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (cs_fall_q) begin
            state_q <= RECV;
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RECV: begin
          if (cs_rise_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (cnt_q == CNT_FULL) begin
              if (!valid_q || frm_if.frame_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
            end else begin
              err_q <= 1'b1;
            end
          end else if (sck_rise_q) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], mosi_smp_q};
            if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign frm_if.frame_data  = data_q;
  assign frm_if.frame_valid = valid_q;
  assign frm_if.frame_err   = err_q;
  assign frm_if.overrun     = ovr_q;
  assign frm_if.busy        = busy_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: directed cases plus random frames against a frame-level model.
module tb_spi_frame_rx;

  logic clk = 1'b0;
  logic rst, sck, cs_n, mosi;

  always #5 clk = ~clk;

  spi_frame_rx_if #(.FRAME_BITS(16)) bus ();

  spi_frame_rx #(.FRAME_BITS(16), .SYNC_STAGES(2)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .sck_in_i  (sck),
    .cs_n_in_i (cs_n),
    .mosi_in_i (mosi),
    .frm_if    (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] m_data  = '0;
  bit          m_valid = 1'b0;
  int          m_err_total = 0;
  int          m_ov_total  = 0;

  int err_cnt = 0, ov_cnt = 0, both_cnt = 0, busy_cnt = 0, valid_cnt = 0;

  always @(negedge clk) begin
    if (bus.frame_err) err_cnt++;
    if (bus.overrun) ov_cnt++;
    if (bus.frame_err && bus.overrun) both_cnt++;
    if (bus.busy) busy_cnt++;
    if (bus.frame_valid) valid_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one chip-select window of nbits (MSB-first from bits) and checks the
  // outcome on the commit edge. rst_at >= 0 pulses reset before that bit index.
  task automatic send_frame(input int nbits, input logic [31:0] bits,
                            input bit rdy_commit, input int rst_at);
    bit was_reset = 1'b0;
    bit exp_err = 1'b0;
    bit exp_ov  = 1'b0;
    cs_n = 1'b0;
    cyc(4);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        was_reset = 1'b1;
        m_valid = 1'b0;
        m_data  = '0;
      end
      mosi = bits[nbits-1-i];
      cyc(4);
      sck = 1'b1;
      cyc(4);
      sck = 1'b0;
      if (i == 0) check("busy_in_frame", bus.busy, !was_reset);
    end
    cyc(4);
    cs_n = 1'b1;
    mosi = 1'b0;
    cyc(3);
    check("pre_valid", bus.frame_valid, m_valid);
    check("pre_busy", bus.busy, !was_reset);
    check("pre_err", bus.frame_err, 1'b0);
    if (rdy_commit) bus.frame_ready = 1'b1;
    cyc(1);
    bus.frame_ready = 1'b0;

    if (rdy_commit && m_valid) m_valid = 1'b0;
    if (!was_reset) begin
      if (nbits == 16) begin
        if (!m_valid) begin
          m_data  = bits[15:0];
          m_valid = 1'b1;
        end else begin
          exp_ov = 1'b1;
        end
      end else begin
        exp_err = 1'b1;
      end
    end
    if (exp_err) m_err_total++;
    if (exp_ov) m_ov_total++;

    check("valid", bus.frame_valid, m_valid);
    check("data", bus.frame_data, m_data);
    check("err", bus.frame_err, exp_err);
    check("overrun", bus.overrun, exp_ov);
    check("busy_end", bus.busy, 1'b0);
    cyc(1);
    check("err_width", bus.frame_err, 1'b0);
    check("ov_width", bus.overrun, 1'b0);
    cyc(3);
  endtask

  task automatic consume();
    bus.frame_ready = 1'b1;
    cyc(1);
    bus.frame_ready = 1'b0;
    m_valid = 1'b0;
    check("consume_valid", bus.frame_valid, 1'b0);
    check("consume_data", bus.frame_data, m_data);
  endtask

  initial begin
    int n;
    logic [31:0] d;
    bit r;
    rst = 1'b1;
    sck = 1'b1;
    cs_n = 1'b1;
    mosi = 1'b0;
    bus.frame_ready = 1'b0;
    cyc(3);
    check("rst_valid", bus.frame_valid, 1'b0);
    check("rst_data", bus.frame_data, 16'h0);
    check("rst_err", bus.frame_err, 1'b0);
    check("rst_ov", bus.overrun, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    cyc(4);
    for (int i = 0; i < 20; i++) begin
      sck = 1'b0;
      cyc(4);
      sck = 1'b1;
      cyc(4);
    end
    sck = 1'b0;
    cyc(4);
    check("idle_busy", busy_cnt, 0);
    check("idle_valid", valid_cnt, 0);
    check("idle_err", err_cnt, 0);

    send_frame(16, 32'h8A5C, 1'b0, -1);
    consume();
    send_frame(15, 32'h1ABC, 1'b0, -1);
    send_frame(17, 32'h1F0F0, 1'b0, -1);

    send_frame(16, 32'h1234, 1'b0, -1);
    send_frame(16, 32'h5678, 1'b0, -1);
    consume();

    send_frame(16, 32'h1234, 1'b0, -1);
    send_frame(16, 32'h5678, 1'b1, -1);
    consume();

    send_frame(16, 32'hABCD, 1'b0, 8);
    send_frame(16, 32'hF00D, 1'b0, -1);
    consume();

    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 3))
        0: n = 15;
        3: n = 17;
        default: n = 16;
      endcase
      d = $urandom;
      r = 1'($urandom_range(0, 1));
      send_frame(n, d, r, -1);
      if ($urandom_range(0, 1) == 1) consume();
    end

    check("err_total", err_cnt, m_err_total);
    check("ov_total", ov_cnt, m_ov_total);
    check("err_ov_overlap", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
